// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: state encoding, frame width, bit-timing helpers
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // One bit period in system clocks; the +1 matches the transmitter's divider.
  function automatic int bit_clks(input int freq, input int baud);
    return freq / baud + 1;
  endfunction

  function automatic int half_clks(input int freq, input int baud);
    return bit_clks(freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - serial line and byte holding-register handshake of the UART receiver
interface uart_receiver_if;
  import uart_pkg::*;

  logic                 RxD;
  logic [DATA_BITS-1:0] RxData;
  logic                 dataValid;
  logic                 dataAck;
  logic                 framingError;
  logic                 overrun;
  logic                 errClear;
  logic                 isBusy;

  modport master (
    input  RxD,
    input  dataAck,
    input  errClear,
    output RxData,
    output dataValid,
    output framingError,
    output overrun,
    output isBusy
  );

  modport slave (
    output RxD,
    output dataAck,
    output errClear,
    input  RxData,
    input  dataValid,
    input  framingError,
    input  overrun,
    input  isBusy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - RxD 2-flop synchroniser; UART_RX_MAJORITY_EN adds a 3-sample majority filter
// rxs feeds edge detection; sample feeds bit decisions.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic rxs,
  output logic sample
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      meta <= rxd;
      rxs  <= meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is rxs one clock ago, hist[1] two clocks ago.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rxs};
    end
  end

  assign sample = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = rxs;
`endif

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with holding register, valid/ack handshake, sticky error flags
// UART_RX_MAJORITY_EN: decide each bit one clock late from a 2-of-3 majority around the centre.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int W5Frequency = 6_250_000,
  parameter int baudRate    = 230400
) (
  input  logic             clk,
  input  logic             reset,
  uart_receiver_if.master  bus
);

  localparam int BIT_CLKS = bit_clks(W5Frequency, baudRate);
  localparam int HALF     = half_clks(W5Frequency, baudRate);

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ_DLY = 1;
`else
  localparam int MAJ_DLY = 0;
`endif

  // With the majority filter the decision lands one clock after the centre, and the
  // counter restarts at 1 so the bit period is still BIT_CLKS.
  localparam int START_END = HALF - 1 + MAJ_DLY;
  localparam int BIT_END   = BIT_CLKS - 1 + MAJ_DLY;
  localparam int CNT_W     = $clog2(BIT_END + 1);
  localparam int IDX_W     = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_START_END = CNT_W'(START_END);
  localparam logic [CNT_W-1:0] CNT_BIT_END   = CNT_W'(BIT_END);
  localparam logic [CNT_W-1:0] CNT_REBASE    = CNT_W'(MAJ_DLY);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_MAX       = IDX_W'(DATA_BITS);

  logic rxs;
  logic sample;

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .rxd    (bus.RxD),
    .rxs    (rxs),
    .sample (sample)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 commit;
  logic                 frame_err;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_BIT_END) ? c : c + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_MAX) ? i : i + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    busy_d    = busy_q;
    commit    = 1'b0;
    frame_err = 1'b0;

    if (bus.dataAck && valid_q) begin
      valid_d = 1'b0;
    end
    if (bus.errClear) begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end

    case (state_q)
      WAIT_IDLE: begin
        if (rxs) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (cnt_q == CNT_START_END) begin
          if (sample) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
            cnt_d   = CNT_REBASE;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      DATA: begin
        if (cnt_q == CNT_BIT_END) begin
          shift_d = {sample, shift_q[DATA_BITS-1:1]};
          cnt_d   = CNT_REBASE;
          idx_d   = idx_inc(idx_q);
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      STOP: begin
        if (cnt_q == CNT_BIT_END) begin
          if (sample) begin
            commit  = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            // Stay busy until the line returns high so a stuck-low line is not re-framed.
            frame_err = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end
      default: begin
        state_d = WAIT_IDLE;
      end
    endcase

    // A new byte always lands; an ack in the same cycle consumes the old one, so no overrun.
    if (commit) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !bus.dataAck) begin
        ovr_d = 1'b1;
      end
    end
    if (frame_err) begin
      ferr_d = 1'b1;
    end
  end

  assign bus.RxData       = data_q;
  assign bus.dataValid    = valid_q;
  assign bus.framingError = ferr_q;
  assign bus.overrun      = ovr_q;
  assign bus.isBusy       = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
// Frames are driven one bit per 28 clocks; every task starts and ends 1 time unit after a rising edge.
module tb_uart_receiver;

  localparam int BIT_CLKS = 28;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_MAX     = 270;
  localparam int COMMIT_EDGE = 270;
  localparam int GLITCH_MAX  = 18;
`else
  localparam int LAT_MAX     = 269;
  localparam int COMMIT_EDGE = 269;
  localparam int GLITCH_MAX  = 17;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  uart_receiver_if bus ();

  uart_receiver #(
    .W5Frequency (6_250_000),
    .baudRate    (230400)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.RxD = b;
    idle(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic pulse_ack;
    bus.dataAck = 1'b1;
    idle(1);
    bus.dataAck = 1'b0;
  endtask

  task automatic pulse_clear;
    bus.errClear = 1'b1;
    idle(1);
    bus.errClear = 1'b0;
  endtask

  task automatic test_reset;
    bus.RxD = 1'b1;
    bus.dataAck = 1'b0;
    bus.errClear = 1'b0;
    reset = 1'b1;
    idle(3);
    n_checks++;
    if ({bus.RxData, bus.dataValid, bus.framingError, bus.overrun, bus.isBusy} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 000",
               {bus.RxData, bus.dataValid, bus.framingError, bus.overrun, bus.isBusy});
    end
    reset = 1'b0;
    idle(2);
    n_checks++;
    if ({bus.dataValid, bus.isBusy} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: valid/busy got %b, expected 00", {bus.dataValid, bus.isBusy});
    end
  endtask

  task automatic test_basic;
    int n = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (bus.dataValid !== 1'b1 && n < 300) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    n_checks++;
    if (n < 263 || n > LAT_MAX) begin
      n_fail++;
      $display("FAIL latency: got %0d clk, expected 263..%0d", n, LAT_MAX);
    end
    idle(50);
    n_checks++;
    if ({bus.RxData, bus.dataValid} !== {8'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL hold_a5: data/valid got %h/%b, expected a5/1", bus.RxData, bus.dataValid);
    end
    n_checks++;
    if ({bus.framingError, bus.overrun} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_flags: got %b, expected 00", {bus.framingError, bus.overrun});
    end
    pulse_ack();
    n_checks++;
    if (bus.dataValid !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_clears: valid got %b, expected 0", bus.dataValid);
    end
    pulse_ack();
    n_checks++;
    if ({bus.RxData, bus.dataValid, bus.overrun} !== {8'hA5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_ack: data/valid/ovr got %h/%b/%b, expected a5/0/0",
               bus.RxData, bus.dataValid, bus.overrun);
    end
  endtask

  task automatic test_glitch;
    int   fall = 0;
    logic seen = 1'b0;
    bus.RxD = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (n == 6) bus.RxD = 1'b1;
      if (bus.isBusy === 1'b1) seen = 1'b1;
      else if (seen && fall == 0) fall = n;
    end
    n_checks++;
    if (!seen || fall == 0 || fall > GLITCH_MAX) begin
      n_fail++;
      $display("FAIL glitch_busy: seen=%b fall=%0d, expected seen=1 fall<=%0d", seen, fall, GLITCH_MAX);
    end
    idle(300);
    n_checks++;
    if ({bus.dataValid, bus.framingError, bus.overrun} !== 3'b000) begin
      n_fail++;
      $display("FAIL glitch_quiet: valid/ferr/ovr got %b, expected 000",
               {bus.dataValid, bus.framingError, bus.overrun});
    end
  endtask

  task automatic test_framing;
    send_frame(8'h3C, 1'b0);
    n_checks++;
    if ({bus.framingError, bus.dataValid, bus.isBusy, bus.RxData} !== {3'b101, 8'hA5}) begin
      n_fail++;
      $display("FAIL frame_err: ferr/valid/busy/data got %b%b%b/%h, expected 101/a5",
               bus.framingError, bus.dataValid, bus.isBusy, bus.RxData);
    end
    bus.RxD = 1'b1;
    idle(5);
    n_checks++;
    if (bus.isBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_recover: busy got %b, expected 0", bus.isBusy);
    end
    send_frame(8'h55, 1'b1);
    n_checks++;
    if ({bus.RxData, bus.dataValid, bus.framingError} !== {8'h55, 2'b11}) begin
      n_fail++;
      $display("FAIL after_frame_err: data/valid/ferr got %h/%b/%b, expected 55/1/1",
               bus.RxData, bus.dataValid, bus.framingError);
    end
    pulse_ack();
    pulse_clear();
    n_checks++;
    if (bus.framingError !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: ferr got %b, expected 0", bus.framingError);
    end
    fork
      send_frame(8'h3C, 1'b0);
      begin
        idle(COMMIT_EDGE - 1);
        bus.errClear = 1'b1;
        idle(1);
        bus.errClear = 1'b0;
      end
    join
    n_checks++;
    if (bus.framingError !== 1'b1) begin
      n_fail++;
      $display("FAIL err_wins: ferr got %b, expected 1", bus.framingError);
    end
    bus.RxD = 1'b1;
    idle(5);
    pulse_clear();
  endtask

  task automatic test_back_to_back;
    send_frame(8'h01, 1'b1);
    n_checks++;
    if ({bus.RxData, bus.dataValid, bus.overrun} !== {8'h01, 2'b10}) begin
      n_fail++;
      $display("FAIL first_byte: data/valid/ovr got %h/%b/%b, expected 01/1/0",
               bus.RxData, bus.dataValid, bus.overrun);
    end
    send_frame(8'h02, 1'b1);
    n_checks++;
    if ({bus.RxData, bus.dataValid, bus.overrun} !== {8'h02, 2'b11}) begin
      n_fail++;
      $display("FAIL overrun: data/valid/ovr got %h/%b/%b, expected 02/1/1",
               bus.RxData, bus.dataValid, bus.overrun);
    end
    pulse_ack();
    pulse_clear();
    fork
      begin
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
      end
      begin
        idle(10 * BIT_CLKS + COMMIT_EDGE - 1);
        bus.dataAck = 1'b1;
        idle(1);
        bus.dataAck = 1'b0;
      end
    join
    n_checks++;
    if ({bus.RxData, bus.dataValid, bus.overrun} !== {8'h02, 2'b10}) begin
      n_fail++;
      $display("FAIL ack_on_commit: data/valid/ovr got %h/%b/%b, expected 02/1/0",
               bus.RxData, bus.dataValid, bus.overrun);
    end
    pulse_ack();
  endtask

  task automatic test_reset_midframe;
    bus.RxD = 1'b0;
    idle(100);
    reset = 1'b1;
    idle(3);
    n_checks++;
    if ({bus.RxData, bus.dataValid, bus.framingError, bus.overrun, bus.isBusy} !== 12'h000) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h, expected 000",
               {bus.RxData, bus.dataValid, bus.framingError, bus.overrun, bus.isBusy});
    end
    reset = 1'b0;
    idle(4);
    bus.RxD = 1'b1;
    idle(40);
    n_checks++;
    if ({bus.dataValid, bus.framingError, bus.overrun, bus.isBusy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL no_spurious: valid/ferr/ovr/busy got %b, expected 0000",
               {bus.dataValid, bus.framingError, bus.overrun, bus.isBusy});
    end
    send_frame(8'h7E, 1'b1);
    idle(2);
    n_checks++;
    if ({bus.RxData, bus.dataValid, bus.framingError} !== {8'h7E, 2'b10}) begin
      n_fail++;
      $display("FAIL after_reset_7e: data/valid/ferr got %h/%b/%b, expected 7e/1/0",
               bus.RxData, bus.dataValid, bus.framingError);
    end
    pulse_ack();
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    bus.RxD = 1'b1;
    idle(14);
    bus.RxD = 1'b0;
    idle(1);
    bus.RxD = 1'b1;
    idle(13);
    for (int i = 4; i < 8; i++) drive_bit(1'b1);
    drive_bit(1'b1);
    n_checks++;
    if ({bus.RxData, bus.dataValid} !== {8'hFF, 1'b1}) begin
      n_fail++;
      $display("FAIL majority_ff: data/valid got %h/%b, expected ff/1", bus.RxData, bus.dataValid);
    end
    pulse_ack();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
